alu_seq: RTL and testbench

Parametrised, handshaked ALU with registered results and status flags. Accepts one operation per valid/ready transfer and computes it in one cycle, or over N cycles for the optional iterative multiply. It holds result and flags stable until the consumer takes them. It sits between decode and writeback in the datapath and feeds the status register with correctly defined Z/C/N/V flags at any data width.

---
 rtl/alu_seq_if.sv | 18 +
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq: valid/ready in, valid/ready out.
interface alu_seq_if #(parameter int N = 32);
  logic         in_valid, in_ready;
  logic [3:0]   op;
  logic [N-1:0] a, b;
  logic         out_valid, out_ready;
  logic [N-1:0] r;
  logic         zero, carry, negative, overflow, err, busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r, zero, carry, negative, overflow, err, busy
  );
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r, zero, carry, negative, overflow, err, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags. Define ALU_SEQ_MUL_EN to build the
// N-cycle shift-add multiplier; otherwise MUL decodes as an illegal opcode.
module alu_seq #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  alu_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam int         CW     = $clog2(N);
`endif

  typedef struct packed {
    logic [N-1:0] r;
    logic         zero, carry, negative, overflow, err;
  } res_t;

  logic [1:0]   state;
  res_t         res_q, res_d;
  logic         accept, is_mul;
  logic [N:0]   sum, diff;
  logic [SHW-1:0] sh;

  assign bus.in_ready = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign sum          = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff         = {1'b0, bus.a} - {1'b0, bus.b};
  assign sh           = bus.b[SHW-1:0];

  always_comb begin
    res_d = '0;
    case (bus.op)
      4'd0: begin
        res_d.r        = sum[N-1:0];
        res_d.carry    = sum[N];
        res_d.overflow = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      4'd1, 4'd10: begin
        // Bit N of the widened difference is the unsigned borrow.
        res_d.r        = diff[N-1:0];
        res_d.carry    = diff[N];
        res_d.overflow = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
      end
      4'd2: res_d.r = bus.a & bus.b;
      4'd3: res_d.r = bus.a | bus.b;
      4'd4: res_d.r = bus.a ^ bus.b;
      4'd5: res_d.r = bus.a << sh;
      4'd6: res_d.r = bus.a >> sh;
      4'd7: res_d.r = $signed(bus.a) >>> sh;
      4'd8: res_d.r = {bus.b[N/2-1:0], {(N/2){1'b0}}};
      4'd9: res_d.r = {{(N/2){1'b0}}, bus.b[N/2-1:0]};
      default: res_d.err = 1'b1;
    endcase
    res_d.zero     = (res_d.r == '0);
    res_d.negative = res_d.r[N-1];
  end

`ifdef ALU_SEQ_MUL_EN
  logic [N-1:0]   mcand, mplier;
  logic [2*N-1:0] acc, acc_nx;
  logic [N:0]     hi;
  logic [CW-1:0]  count;

  assign is_mul = (bus.op == 4'd11);
  // Add into the high half, then shift the whole accumulator (with carry-out) right.
  assign hi     = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nx = {hi, acc[N-1:1]};
  assign bus.busy = (state == S_MUL);
`else
  assign is_mul   = 1'b0;
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      res_q <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
`endif
    end else if (accept && !is_mul) begin
      res_q <= res_d;
      state <= S_DONE;
`ifdef ALU_SEQ_MUL_EN
    end else if (accept) begin
      state  <= S_MUL;
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
      count  <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nx;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == CW'(N-1)) begin
        state <= S_DONE;
        res_q <= {acc_nx[N-1:0], ~|acc_nx[N-1:0], |acc_nx[2*N-1:N], acc_nx[N-1], 1'b0, 1'b0};
      end
`endif
    end else if ((state == S_DONE) && bus.out_ready) begin
      state <= S_IDLE;
    end
  end

  assign bus.out_valid = (state == S_DONE);
  assign bus.r         = res_q.r;
  assign bus.zero      = res_q.zero;
  assign bus.carry     = res_q.carry;
  assign bus.negative  = res_q.negative;
  assign bus.overflow  = res_q.overflow;
  assign bus.err       = res_q.err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=32): queue-based reference model checked every cycle,
// plus literal expectations for the headline cases.
module tb_alu_seq;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N)) bus ();
  alu_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] r;
    logic        z, c, n, v, e;
    logic        mul;
    int          due;
  } exp_t;

  exp_t q[$];
  int   pop_log[$];
  int   checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
  bit   ovx, bzx, irx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    logic [63:0] p;
    e.r = 0; e.c = 0; e.v = 0; e.e = 0; e.mul = 0; e.due = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin
        s = sa + sb; e.r = a + b;
        e.c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1, 4'd10: begin
        s = sa - sb; e.r = a - b;
        e.c = a < b;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = a << b[4:0];
      4'd6: e.r = a >> b[4:0];
      4'd7: e.r = $signed(a) >>> b[4:0];
      4'd8: e.r = {b[15:0], 16'h0};
      4'd9: e.r = {16'h0, b[15:0]};
`ifdef ALU_SEQ_MUL_EN
      4'd11: begin
        p = {32'd0, a} * {32'd0, b};
        e.r = p[31:0]; e.c = (p[63:32] != 0); e.mul = 1;
      end
`endif
      default: e.e = 1;
    endcase
    e.z = (e.r == 0);
    e.n = e.r[31];
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Per-cycle comparison of the DUT against the queue model.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_outputs", {bus.r, bus.zero, bus.carry, bus.negative, bus.overflow, bus.err}, 0);
    end else begin
      ovx = (q.size() > 0) && (cyc >= q[0].due);
      bzx = (q.size() > 0) && q[0].mul && (cyc < q[0].due);
      irx = (q.size() == 0) || (ovx && bus.out_ready);
      chk("out_valid", bus.out_valid, ovx);
      chk("busy", bus.busy, bzx);
      chk("in_ready", bus.in_ready, irx);
      if (bus.busy) busy_cnt++;
      if (ovx && bus.out_valid)
        chk("result", {bus.r, bus.zero, bus.carry, bus.negative, bus.overflow, bus.err},
            {q[0].r, q[0].z, q[0].c, q[0].n, q[0].v, q[0].e});
      if (ovx && bus.out_ready) begin
        void'(q.pop_front());
        pop_log.push_back(cyc);
      end
      if (bus.in_valid && irx) begin
        exp_t e;
        e = model(bus.op, bus.a, bus.b);
        e.due = cyc + (e.mul ? N + 1 : 1);
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb);
    bit ok;
    ok = 0;
    bus.in_valid = 1; bus.op = o; bus.a = aa; bus.b = bb;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    chk("send_accepted", ok, 1);
    bus.in_valid = 0; bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
  endtask

  task automatic lit(input string name, input logic [3:0] o, input logic [31:0] aa,
                     input logic [31:0] bb, input logic [31:0] er, input logic [4:0] ef,
                     input int lat);
    bit seen;
    int k;
    seen = 0; k = 0;
    send(o, aa, bb);
    for (int t = 1; t <= 60 && !seen; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; k = t; end
    end
    chk({name, "_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_latency"}, k, lat);
      chk({name, "_value"}, {bus.r, bus.zero, bus.carry, bus.negative, bus.overflow, bus.err},
          {er, ef});
    end
    @(posedge clk); #1;
  endtask

  localparam int NV = 16;
  logic [3:0]  vop [NV] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                            4'd5, 4'd7, 4'd9, 4'd10, 4'd11, 4'd11, 4'd12, 4'd14};
  logic [31:0] va  [NV] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
                            32'hF0F0F0F0, 32'h0F0F0000, 32'hA5A5A5A5, 32'h00000001,
                            32'h00000003, 32'h7FF00000, 32'h00000000, 32'h00000003,
                            32'hFFFFFFFF, 32'h00000003, 32'h12345678, 32'h1};
  logic [31:0] vb  [NV] = '{32'h00000001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF,
                            32'h3C3C3C3C, 32'h000000FF, 32'hA5A5A5A5, 32'h0000001F,
                            32'h00000021, 32'h00000004, 32'hABCD1234, 32'h00000007,
                            32'h00000002, 32'h00000005, 32'h9, 32'h2};

  initial begin
    int n0, pulses;
    bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    //                                   r             {z,c,n,v,err}  latency
    lit("add_ovf",   4'd0,  32'h7FFFFFFF, 32'd1,  32'h80000000, 5'b00110, 1);
    lit("sub_borrow",4'd1,  32'd0,        32'd1,  32'hFFFFFFFF, 5'b01100, 1);
    lit("cmp_eq",    4'd10, 32'd5,        32'd5,  32'h00000000, 5'b10000, 1);
    lit("sra",       4'd7,  32'h80000000, 32'd31, 32'hFFFFFFFF, 5'b00100, 1);
    lit("srl",       4'd6,  32'h80000000, 32'd31, 32'h00000001, 5'b00000, 1);
    lit("lui",       4'd8,  32'd0,        32'h1234, 32'h12340000, 5'b00000, 1);
    lit("illegal",   4'd15, 32'd3,        32'd4,  32'h00000000, 5'b10001, 1);

    busy_cnt = 0;
`ifdef ALU_SEQ_MUL_EN
    lit("mul",       4'd11, 32'h10000, 32'h10000, 32'h0, 5'b11000, 33);
    chk("mul_busy_cycles", busy_cnt, 32);
`else
    lit("mul_off",   4'd11, 32'h10000, 32'h10000, 32'h0, 5'b10001, 1);
    chk("mul_busy_cycles", busy_cnt, 0);
`endif

    for (int i = 0; i < NV; i++) send(vop[i], va[i], vb[i]);
    repeat (40) @(posedge clk);
    #1;

    // Stall the consumer, then stream back-to-back adds.
    bus.out_ready = 0;
    send(4'd0, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_r", bus.r, 32'd30);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    n0 = pop_log.size();
    send(4'd0, 32'd1, 32'd1);
    send(4'd0, 32'd2, 32'd2);
    send(4'd0, 32'd3, 32'd3);
    send(4'd0, 32'd4, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_count", pop_log.size() - n0, 5);
    if (pop_log.size() - n0 == 5)
      chk("stream_consecutive", pop_log[n0+4] - pop_log[n0+1], 3);

    // Reset in the middle of a multiply: nothing may be emitted afterwards.
    send(4'd11, 32'h1234, 32'h5678);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);

    lit("illegal_after_rst", 4'd15, 32'hFFFF, 32'h1, 32'h0, 5'b10001, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
